axi_xbar_ax_decode: RTL and testbench
=====================================

Name: axi_xbar_ax_decode

Overview:
Per-slave-port AW/AR address routing stage of the AXI crossbar. It sits between an upstream AXI master connection and the demux. It decodes each request address against the xbar_rule_32_t address map and selects a destination master port, or the decode-error port. It enforces per-ID ordering: all outstanding transactions of one ID must target the same destination. The result goes to a registered valid/ready output.

Parameters:
NoMstPorts, 4, number of crossbar master ports (xbar_cfg_t.NoMstPorts)
NoAddrRules, 4, number of address-map rules (xbar_cfg_t.NoAddrRules)
AxiIdWidth, 4, slave-port ID width (xbar_cfg_t.AxiIdWidthSlvPorts)
AxiIdUsed, 2, low ID bits used for ordering decisions; 1..AxiIdWidth (xbar_cfg_t.AxiIdUsedSlvPorts)
MaxTrans, 8, max outstanding transactions per ID; >=1 (xbar_cfg_t.MaxMstTrans)
SelW, $clog2(NoMstPorts+1), select width; value NoMstPorts means decode error
CntW, $clog2(MaxTrans+1), counter width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
addr_map_i  in  NoAddrRules*96  packed array of xbar_rule_32_t {idx, start_addr, end_addr}; quasi-static
slv_valid_i  in  1  request valid
slv_ready_o  out  1  request ready
slv_id_i  in  AxiIdWidth  request ID
slv_addr_i  in  32  request address
mst_valid_o  out  1  routed request valid
mst_ready_i  in  1  downstream ready
mst_id_o  out  AxiIdWidth  registered ID
mst_addr_o  out  32  registered address
mst_sel_o  out  SelW  destination port index
mst_decerr_o  out  1  1 when no rule matched
rsp_done_i  in  1  pulse: one transaction completed (last R beat or B handshake)
rsp_id_i  in  AxiIdWidth  ID of completed transaction
idle_o  out  1  1 when all ID counters are 0 and mst_valid_o is 0

Behaviour:
- Reset (async, rst_ni=0): mst_valid_o=0, mst_id_o/mst_addr_o/mst_sel_o/mst_decerr_o=0, all counters=0, all dest=0, idle_o=1. slv_ready_o=0 while in reset. Assertion of reset mid-operation drops any held output request and clears all tracking.
- Decode (combinational on slv_addr_i): rule r matches if start_addr <= addr < end_addr; unsigned compare; end exclusive.
  - The lowest-numbered matching rule wins.
  - sel = rule.idx.
  - If no rule matches, or rule.idx >= NoMstPorts: sel = NoMstPorts, decerr = 1.
  - A rule with start_addr >= end_addr never matches.
- ID tracker: one entry per value of t = slv_id_i[AxiIdUsed-1:0], 2^AxiIdUsed entries. Each entry holds cnt (CntW bits) and dest (SelW bits).
- Admission: pass = (cnt[t]==0) || (dest[t]==sel && cnt[t]<MaxTrans).
- Handshake:
  - slv_ready_o = pass && (!mst_valid_o || mst_ready_i).
  - slv_ready_o must not depend combinationally on mst_ready_i when mst_valid_o=0.
- Accept (slv_valid_i && slv_ready_o):
  - Next cycle: mst_valid_o=1; mst_id_o, mst_addr_o, mst_sel_o, mst_decerr_o latched. Latency is 1 cycle.
  - cnt[t] increments and dest[t]=sel.
- Output: mst_valid_o stays 1 with stable payload until mst_ready_i=1. It clears on handshake unless a new accept occurs in the same cycle. Back-to-back accepts give full throughput.
- Completion (rsp_done_i=1): cnt[u] decrements, u = rsp_id_i[AxiIdUsed-1:0].
  - rsp_done_i with cnt[u]==0 is ignored; counter stays 0. The bench flags it as a protocol error.
- Same-cycle accept and completion on the same entry: cnt unchanged, dest=sel. Different entries update independently.
- Stall: while pass=0, slv_ready_o=0. The request is held upstream, with no reordering and no drop, until completions drain cnt[t] to 0. The request is then accepted and dest[t] is retargeted.
- cnt saturates at MaxTrans: no increment possible because pass=0.
- Decode-error requests are tracked like any other destination (dest=NoMstPorts).
- idle_o is combinational from registered state.

Test Plan:
- Map {0:[0x0000_0000,0x1000_0000)->0, 1:[0x1000_0000,0x2000_0000)->1, 2:[0x2000_0000,0x3000_0000)->2, 3:[0x8000_0000,0x9000_0000)->3}. Send addr 0x1000_0004 id 0x1 -> 1 cycle later mst_valid_o=1, mst_sel_o=1, mst_decerr_o=0, cnt[1]=1.
- addr 0x4000_0000 -> mst_sel_o=4, mst_decerr_o=1. Boundary addr 0x2FFF_FFFF -> sel 2. addr 0x3000_0000 -> sel 4.
- Overlapping rules, rule0 [0x0,0x2000_0000)->3 and rule1 [0x1000_0000,0x2000_0000)->1; addr 0x1800_0000 -> sel 3 (lowest rule wins).
- id 0x2 to port 0 accepted. Then id 0x6 (same low 2 bits) to port 2 -> slv_ready_o=0 until rsp_done_i with rsp_id_i=0x2. The next cycle it is accepted and dest[2]=2.
- MaxTrans=8: 8 accepts id 0x0 to port 1, no completions -> 9th stalls. A single rsp_done_i in the cycle of the 9th attempt keeps it stalled for that cycle; it is accepted the next cycle with cnt=8.
- mst_ready_i held 0 for 5 cycles with 2 requests queued -> payload stable and only 1 accepted. Assert rst_ni=0 mid-stall -> mst_valid_o=0 immediately, idle_o=1, counters 0.

Source files
------------

// File: rtl/axi_xbar_ax_decode.sv
// AW/AR address routing stage of the AXI crossbar: decodes the request address against the
// rule map, enforces single-destination-per-ID ordering and registers the routed request.
module axi_xbar_ax_decode #(
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned NoAddrRules = 4,
    parameter int unsigned AxiIdWidth  = 4,
    parameter int unsigned AxiIdUsed   = 2,
    parameter int unsigned MaxTrans    = 8,
    parameter int unsigned SelW        = $clog2(NoMstPorts + 1),
    parameter int unsigned CntW        = $clog2(MaxTrans + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NoAddrRules*96-1:0]   addr_map_i,
    input  logic                        slv_valid_i,
    output logic                        slv_ready_o,
    input  logic [AxiIdWidth-1:0]       slv_id_i,
    input  logic [31:0]                 slv_addr_i,
    output logic                        mst_valid_o,
    input  logic                        mst_ready_i,
    output logic [AxiIdWidth-1:0]       mst_id_o,
    output logic [31:0]                 mst_addr_o,
    output logic [SelW-1:0]             mst_sel_o,
    output logic                        mst_decerr_o,
    input  logic                        rsp_done_i,
    input  logic [AxiIdWidth-1:0]       rsp_id_i,
    output logic                        idle_o
);

    localparam int unsigned NoIds = 1 << AxiIdUsed;
    localparam int unsigned RuleW = 96;

    // Each rule is packed as {idx, start_addr, end_addr}, idx in the top word.
    logic [31:0] rule_idx   [NoAddrRules];
    logic [31:0] rule_start [NoAddrRules];
    logic [31:0] rule_end   [NoAddrRules];

    for (genvar r = 0; r < NoAddrRules; r++) begin : g_rule
        assign rule_idx[r]   = addr_map_i[r*RuleW+64 +: 32];
        assign rule_start[r] = addr_map_i[r*RuleW+32 +: 32];
        assign rule_end[r]   = addr_map_i[r*RuleW    +: 32];
    end

    logic [SelW-1:0] dec_sel;
    logic            dec_err;
    logic            dec_hit;

    // First matching rule decides; an out-of-range idx on that rule is a decode error.
    always_comb begin
        dec_sel = SelW'(NoMstPorts);
        dec_err = 1'b1;
        dec_hit = 1'b0;
        for (int r = 0; r < NoAddrRules; r++) begin
            if (!dec_hit && (slv_addr_i >= rule_start[r]) && (slv_addr_i < rule_end[r])) begin
                dec_hit = 1'b1;
                if (rule_idx[r] < 32'(NoMstPorts)) begin
                    dec_sel = rule_idx[r][SelW-1:0];
                    dec_err = 1'b0;
                end
            end
        end
    end

    logic [CntW-1:0]      cnt_q  [NoIds];
    logic [CntW-1:0]      cnt_d  [NoIds];
    logic [SelW-1:0]      dest_q [NoIds];
    logic [SelW-1:0]      dest_d [NoIds];
    logic [AxiIdUsed-1:0] slv_tid;
    logic [AxiIdUsed-1:0] rsp_tid;
    logic                 pass;
    logic                 accept;
    logic                 mst_valid_q;
    logic                 cnt_zero;
    logic                 unused_rsp_id;

    assign slv_tid       = slv_id_i[AxiIdUsed-1:0];
    assign rsp_tid       = rsp_id_i[AxiIdUsed-1:0];
    assign unused_rsp_id = ^rsp_id_i;

    assign pass = (cnt_q[slv_tid] == '0) ||
                  ((dest_q[slv_tid] == dec_sel) && (cnt_q[slv_tid] < CntW'(MaxTrans)));

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits
    // on ready. Ready only looks at mst_ready_i when the output register is occupied.
    assign slv_ready_o = rst_ni && pass && (!mst_valid_q || mst_ready_i);
    assign accept      = slv_valid_i && slv_ready_o;

    always_comb begin
        for (int i = 0; i < NoIds; i++) begin
            logic inc;
            logic dec;
            cnt_d[i]  = cnt_q[i];
            dest_d[i] = dest_q[i];
            inc = accept && (slv_tid == AxiIdUsed'(i));
            dec = rsp_done_i && (rsp_tid == AxiIdUsed'(i)) && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
            if (inc) begin
                dest_d[i] = dec_sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NoIds; i++) begin
                cnt_q[i]  <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NoIds; i++) begin
                cnt_q[i]  <= cnt_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_valid_q  <= 1'b0;
            mst_id_o     <= '0;
            mst_addr_o   <= '0;
            mst_sel_o    <= '0;
            mst_decerr_o <= 1'b0;
        end else if (accept) begin
            mst_valid_q  <= 1'b1;
            mst_id_o     <= slv_id_i;
            mst_addr_o   <= slv_addr_i;
            mst_sel_o    <= dec_sel;
            mst_decerr_o <= dec_err;
        end else if (mst_ready_i) begin
            mst_valid_q  <= 1'b0;
        end
    end

    always_comb begin
        cnt_zero = 1'b1;
        for (int i = 0; i < NoIds; i++) begin
            if (cnt_q[i] != '0) begin
                cnt_zero = 1'b0;
            end
        end
    end

    assign mst_valid_o = mst_valid_q;
    assign idle_o      = cnt_zero && !mst_valid_q;

endmodule

// File: tb/tb_axi_xbar_ax_decode.sv
// Directed bench for axi_xbar_ax_decode: decode, ordering stalls, saturation, backpressure, reset.
module tb_axi_xbar_ax_decode;

    localparam int W = 40;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [383:0]  addr_map_i;
    logic          slv_valid_i;
    logic          slv_ready_o;
    logic [3:0]    slv_id_i;
    logic [31:0]   slv_addr_i;
    logic          mst_valid_o;
    logic          mst_ready_i;
    logic [3:0]    mst_id_o;
    logic [31:0]   mst_addr_o;
    logic [2:0]    mst_sel_o;
    logic          mst_decerr_o;
    logic          rsp_done_i;
    logic [3:0]    rsp_id_i;
    logic          idle_o;

    logic [W-1:0]  exp_q[$];
    int            out_cnt[4];
    int            n_vec = 0;
    int            n_err = 0;

    axi_xbar_ax_decode dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_map_i(addr_map_i),
        .slv_valid_i(slv_valid_i), .slv_ready_o(slv_ready_o),
        .slv_id_i(slv_id_i), .slv_addr_i(slv_addr_i),
        .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i),
        .mst_id_o(mst_id_o), .mst_addr_o(mst_addr_o),
        .mst_sel_o(mst_sel_o), .mst_decerr_o(mst_decerr_o),
        .rsp_done_i(rsp_done_i), .rsp_id_i(rsp_id_i), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rule(input int r, input logic [31:0] idx, input logic [31:0] st,
                            input logic [31:0] en);
        addr_map_i[r*96 +: 96] = {idx, st, en};
    endtask

    task automatic map_a();
        set_rule(0, 0, 32'h0000_0000, 32'h1000_0000);
        set_rule(1, 1, 32'h1000_0000, 32'h2000_0000);
        set_rule(2, 2, 32'h2000_0000, 32'h3000_0000);
        set_rule(3, 3, 32'h8000_0000, 32'h9000_0000);
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] sel,
                            input logic dec);
        exp_q.push_back({id, addr, sel, dec});
        out_cnt[id[1:0]]++;
    endtask

    // Called at posedge+1; offers the request for up to budget cycles.
    task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] sel,
                        input logic dec, input int budget, output bit accepted);
        accepted    = 1'b0;
        slv_valid_i = 1'b1;
        slv_id_i    = id;
        slv_addr_i  = addr;
        for (int c = 0; c < budget && !accepted; c++) begin
            @(negedge clk_i);
            if (slv_ready_o) begin
                accepted = 1'b1;
                push_exp(id, addr, sel, dec);
            end
            @(posedge clk_i);
            #1;
        end
        slv_valid_i = 1'b0;
    endtask

    task automatic send_ok(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [2:0] sel, input logic dec);
        bit acc;
        send(id, addr, sel, dec, 4, acc);
        chk(tag, 64'(acc), 64'd1);
    endtask

    task automatic done(input logic [3:0] id);
        chk("rsp_protocol", 64'(out_cnt[id[1:0]] > 0), 64'd1);
        rsp_done_i = 1'b1;
        rsp_id_i   = id;
        @(posedge clk_i);
        #1;
        rsp_done_i = 1'b0;
        if (out_cnt[id[1:0]] > 0) out_cnt[id[1:0]]--;
    endtask

    // Scoreboard: every output handshake must match the oldest accepted request.
    always @(negedge clk_i) begin
        if (rst_ni && mst_valid_o && mst_ready_i) begin
            chk("out_has_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
                chk("payload", 64'({mst_id_o, mst_addr_o, mst_sel_o, mst_decerr_o}),
                    64'(exp_q.pop_front()));
        end
    end

    initial begin
        bit acc;
        rst_ni      = 1'b0;
        slv_valid_i = 1'b1;
        slv_id_i    = 4'h1;
        slv_addr_i  = 32'h1000_0000;
        mst_ready_i = 1'b1;
        rsp_done_i  = 1'b0;
        rsp_id_i    = '0;
        addr_map_i  = '0;
        map_a();
        for (int i = 0; i < 4; i++) out_cnt[i] = 0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(mst_valid_o), 64'd0);
        chk("rst_sel", 64'(mst_sel_o), 64'd0);
        chk("rst_decerr", 64'(mst_decerr_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_ready", 64'(slv_ready_o), 64'd0);
        slv_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic route with 1-cycle latency
        send_ok("acc_basic", 4'h1, 32'h1000_0004, 3'd1, 1'b0);
        @(negedge clk_i);
        chk("lat_valid", 64'(mst_valid_o), 64'd1);
        chk("lat_sel", 64'(mst_sel_o), 64'd1);
        chk("lat_decerr", 64'(mst_decerr_o), 64'd0);
        chk("busy_idle", 64'(idle_o), 64'd0);
        @(posedge clk_i);
        #1;
        done(4'h1);
        @(negedge clk_i);
        chk("idle_after_done", 64'(idle_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Decode errors and end-exclusive boundaries
        send_ok("acc_hole", 4'h1, 32'h4000_0000, 3'd4, 1'b1);
        send_ok("acc_last", 4'h2, 32'h2FFF_FFFF, 3'd2, 1'b0);
        send_ok("acc_end", 4'h3, 32'h3000_0000, 3'd4, 1'b1);
        done(4'h1);
        done(4'h2);
        done(4'h3);

        // Overlap priority, empty rule, out-of-range idx
        set_rule(0, 3, 32'h0000_0000, 32'h2000_0000);
        set_rule(1, 1, 32'h1000_0000, 32'h2000_0000);
        set_rule(2, 0, 32'h5000_0000, 32'h5000_0000);
        set_rule(3, 7, 32'h6000_0000, 32'h7000_0000);
        send_ok("acc_overlap", 4'h0, 32'h1800_0000, 3'd3, 1'b0);
        done(4'h0);
        send_ok("acc_empty_rule", 4'h0, 32'h5000_0000, 3'd4, 1'b1);
        send_ok("acc_bad_idx", 4'h0, 32'h6000_0010, 3'd4, 1'b1);
        done(4'h0);
        done(4'h0);
        map_a();

        // Ignored completion on an empty entry must not wrap the counter
        rsp_done_i = 1'b1;
        rsp_id_i   = 4'h3;
        @(posedge clk_i);
        #1;
        rsp_done_i = 1'b0;
        @(negedge clk_i);
        chk("idle_after_spurious", 64'(idle_o), 64'd1);
        @(posedge clk_i);
        #1;
        send_ok("acc_after_spurious", 4'h3, 32'h0000_0100, 3'd0, 1'b0);
        done(4'h3);

        // Per-ID ordering stall and retarget
        send_ok("acc_id2", 4'h2, 32'h0000_0100, 3'd0, 1'b0);
        send(4'h6, 32'h2000_0000, 3'd2, 1'b0, 4, acc);
        chk("stall_id6", 64'(acc), 64'd0);
        slv_valid_i = 1'b1;
        slv_id_i    = 4'h6;
        slv_addr_i  = 32'h2000_0000;
        @(negedge clk_i);
        chk("stall_ready", 64'(slv_ready_o), 64'd0);
        rsp_done_i = 1'b1;
        rsp_id_i   = 4'h2;
        out_cnt[2]--;
        @(posedge clk_i);
        #1;
        rsp_done_i = 1'b0;
        @(negedge clk_i);
        chk("unstall_ready", 64'(slv_ready_o), 64'd1);
        push_exp(4'h6, 32'h2000_0000, 3'd2, 1'b0);
        @(posedge clk_i);
        #1;
        slv_valid_i = 1'b0;
        send(4'h2, 32'h0000_0100, 3'd0, 1'b0, 3, acc);
        chk("retarget_stall", 64'(acc), 64'd0);
        send_ok("retarget_same", 4'h2, 32'h2000_0040, 3'd2, 1'b0);
        done(4'h2);
        done(4'h2);

        // Saturation at MaxTrans
        for (int i = 0; i < 8; i++)
            send_ok("acc_fill", 4'h0, 32'h1000_0000 + 32'(i * 4), 3'd1, 1'b0);
        slv_valid_i = 1'b1;
        slv_id_i    = 4'h0;
        slv_addr_i  = 32'h1000_0100;
        @(negedge clk_i);
        chk("sat_ready", 64'(slv_ready_o), 64'd0);
        rsp_done_i = 1'b1;
        rsp_id_i   = 4'h0;
        out_cnt[0]--;
        @(posedge clk_i);
        #1;
        rsp_done_i = 1'b0;
        @(negedge clk_i);
        chk("sat_release", 64'(slv_ready_o), 64'd1);
        push_exp(4'h0, 32'h1000_0100, 3'd1, 1'b0);
        @(posedge clk_i);
        #1;
        slv_valid_i = 1'b0;
        send(4'h0, 32'h1000_0200, 3'd1, 1'b0, 2, acc);
        chk("sat_full_again", 64'(acc), 64'd0);
        for (int i = 0; i < 8; i++) done(4'h0);
        @(negedge clk_i);
        chk("idle_after_drain", 64'(idle_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Backpressure holds payload; then reset mid-stall
        mst_ready_i = 1'b0;
        send_ok("acc_bp", 4'h1, 32'h1000_0008, 3'd1, 1'b0);
        slv_valid_i = 1'b1;
        slv_id_i    = 4'h1;
        slv_addr_i  = 32'h1000_000C;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("bp_ready", 64'(slv_ready_o), 64'd0);
            chk("bp_valid", 64'(mst_valid_o), 64'd1);
            chk("bp_addr", 64'(mst_addr_o), 64'h1000_0008);
        end
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(mst_valid_o), 64'd0);
        chk("rst_mid_idle", 64'(idle_o), 64'd1);
        chk("rst_mid_ready", 64'(slv_ready_o), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) out_cnt[i] = 0;
        slv_valid_i = 1'b0;
        mst_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send_ok("acc_post_reset", 4'h1, 32'h2000_0000, 3'd2, 1'b0);
        done(4'h1);

        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk_i);
        @(negedge clk_i);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(idle_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
